// File: rtl/snake_dir_ctrl.sv
// Multi-player snake direction controller: edge-detects buttons, filters and queues turns, applies one per step.
// Define SNAKE_DIR_NO_REVERSE_EN to drop presses that would reverse the queued/current direction.
module snake_dir_ctrl #(
    parameter int         NUM_PLAYERS = 1,
    parameter int         QUEUE_DEPTH = 2,
    parameter logic [1:0] RESET_DIR   = 2'b00,
    parameter int         CW          = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_PLAYERS-1:0]    btn_up,
    input  logic [NUM_PLAYERS-1:0]    btn_down,
    input  logic [NUM_PLAYERS-1:0]    btn_right,
    input  logic [NUM_PLAYERS-1:0]    btn_left,
    input  logic                      step,
    output logic [2*NUM_PLAYERS-1:0]  direction,
    output logic [NUM_PLAYERS-1:0]    turned,
    output logic [CW*NUM_PLAYERS-1:0] q_count,
    output logic [NUM_PLAYERS-1:0]    overflow
);

    localparam int            PW   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(QUEUE_DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [1:0] reverse_dir(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_ch
        logic [3:0]    btn, ev, prev_q, prev_d;
        logic [1:0]    dir_q, dir_d, cand, ref_dir;
        logic          turned_q, turned_d, ovf_q, ovf_d;
        logic          cand_vld, drop, want_push, push, pop;
        logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, tail_idx;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [1:0]    mem_q [QUEUE_DEPTH];
        logic [1:0]    mem_d [QUEUE_DEPTH];

        assign btn = {btn_left[p], btn_right[p], btn_down[p], btn_up[p]};

        always_comb begin
            ev       = btn & ~prev_q;
            prev_d   = btn;
            cand_vld = |ev;
            cand     = 2'b11;
            if (ev[0])      cand = 2'b00;
            else if (ev[1]) cand = 2'b01;
            else if (ev[2]) cand = 2'b10;

            // Filters compare against the last queued turn, not the live direction.
            tail_idx = (wr_q == '0) ? LAST : wr_q - PW'(1);
            ref_dir  = (cnt_q != '0) ? mem_q[tail_idx] : dir_q;
            drop     = (cand == ref_dir);
`ifdef SNAKE_DIR_NO_REVERSE_EN
            drop     = drop | (cand == reverse_dir(ref_dir));
`endif
            pop       = step && (cnt_q != '0);
            want_push = cand_vld && !drop;
            push      = want_push && ((cnt_q != FULL) || pop);

            mem_d = mem_q;
            if (push) mem_d[wr_q] = cand;
            wr_d     = push ? ptr_inc(wr_q) : wr_q;
            rd_d     = pop ? ptr_inc(rd_q) : rd_q;
            cnt_d    = cnt_q + CW'(push) - CW'(pop);
            dir_d    = pop ? mem_q[rd_q] : dir_q;
            turned_d = pop;
            ovf_d    = ovf_q | (want_push && (cnt_q == FULL) && !pop);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                // Capture current levels so a button held through reset is not an event.
                prev_q   <= btn;
                dir_q    <= RESET_DIR;
                turned_q <= 1'b0;
                ovf_q    <= 1'b0;
                rd_q     <= '0;
                wr_q     <= '0;
                cnt_q    <= '0;
            end else begin
                prev_q   <= prev_d;
                dir_q    <= dir_d;
                turned_q <= turned_d;
                ovf_q    <= ovf_d;
                rd_q     <= rd_d;
                wr_q     <= wr_d;
                cnt_q    <= cnt_d;
            end
        end

        always_ff @(posedge clk) begin
            mem_q <= mem_d;
        end

        assign direction[2*p +: 2] = dir_q;
        assign turned[p]           = turned_q;
        assign q_count[CW*p +: CW] = cnt_q;
        assign overflow[p]         = ovf_q;
    end

    logic unused_fn;
    assign unused_fn = ^reverse_dir(2'b00);

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl with two players and a two-entry queue.
module tb_snake_dir_ctrl;
    localparam int NP = 2;
    localparam int QD = 2;
    localparam int CW = $clog2(QD + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic [NP-1:0]    btn_up, btn_down, btn_right, btn_left;
    logic             step;
    logic [2*NP-1:0]  direction;
    logic [NP-1:0]    turned;
    logic [CW*NP-1:0] q_count;
    logic [NP-1:0]    overflow;

    int errors = 0;
    int checks = 0;

    snake_dir_ctrl #(
        .NUM_PLAYERS(NP),
        .QUEUE_DEPTH(QD),
        .RESET_DIR  (2'b00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_right(btn_right),
        .btn_left (btn_left),
        .step     (step),
        .direction(direction),
        .turned   (turned),
        .q_count  (q_count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] dir, input logic [1:0] trn,
                           input logic [3:0] cnt, input logic [1:0] ovf);
        chk({tag, ".dir"}, 32'(direction), 32'(dir));
        chk({tag, ".turned"}, 32'(turned), 32'(trn));
        chk({tag, ".qcount"}, 32'(q_count), 32'(cnt));
        chk({tag, ".ovf"}, 32'(overflow), 32'(ovf));
    endtask

    initial begin
        rst = 1'b1; step = 1'b0;
        btn_up = 2'b01; btn_down = '0; btn_right = '0; btn_left = '0;
        tick(); tick();
        chk_all("reset", 4'b0000, 2'b00, 4'h0, 2'b00);

        // Up held through reset: no event; re-press is a duplicate of 00.
        rst = 1'b0; tick();
        chk("held_up.q", 32'(q_count), 32'h0);
        btn_up = 2'b00; tick();
        btn_up = 2'b01; tick();
        chk("repress_up_dup.q", 32'(q_count), 32'h0);
        btn_up = 2'b00;

        // Basic turn to right.
        btn_right = 2'b01; tick();
        chk("basic.q1", 32'(q_count), 32'h1);
        tick();
        chk("basic.q1b", 32'(q_count), 32'h1);
        step = 1'b1; tick(); step = 1'b0;
        chk_all("basic.pop", 4'b0010, 2'b01, 4'h0, 2'b00);
        tick();
        chk("basic.turned_clr", 32'(turned), 32'h0);
        btn_right = 2'b00;

        // Reverse press (left while heading right).
        btn_left = 2'b01; tick();
`ifdef SNAKE_DIR_NO_REVERSE_EN
        chk("rev.q", 32'(q_count), 32'h0);
        step = 1'b1; tick(); step = 1'b0;
        chk_all("rev.step", 4'b0010, 2'b00, 4'h0, 2'b00);
`else
        chk("rev.q", 32'(q_count), 32'h1);
        step = 1'b1; tick(); step = 1'b0;
        chk_all("rev.step", 4'b0011, 2'b01, 4'h0, 2'b00);
`endif

        // Queue an up, then reset together with step: pending turn discarded.
        btn_left = 2'b00; btn_up = 2'b01; tick();
        chk("prerst.q", 32'(q_count), 32'h1);
        rst = 1'b1; step = 1'b1; tick();
        chk_all("midrst", 4'b0000, 2'b00, 4'h0, 2'b00);
        rst = 1'b0; step = 1'b0; btn_up = 2'b00; tick();
        chk("postrst.q", 32'(q_count), 32'h0);

        // Fill queue: right, up, then left overflows.
        btn_right = 2'b01; tick(); btn_right = 2'b00;
        btn_up = 2'b01; tick(); btn_up = 2'b00;
        chk("fill.q2", 32'(q_count), 32'h2);
        btn_left = 2'b01; tick(); btn_left = 2'b00;
        chk_all("ovf", 4'b0000, 2'b00, 4'h2, 2'b01);
        step = 1'b1; tick();
        chk_all("drain1", 4'b0010, 2'b01, 4'h1, 2'b01);
        tick();
        chk_all("drain2", 4'b0000, 2'b01, 4'h0, 2'b01);
        tick(); step = 1'b0;
        chk_all("drain3", 4'b0000, 2'b00, 4'h0, 2'b01);

        // Full queue with simultaneous step and new press.
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst2.ovf", 32'(overflow), 32'h0);
        btn_right = 2'b01; tick(); btn_right = 2'b00;
        btn_up = 2'b01; tick(); btn_up = 2'b00;
        btn_left = 2'b01; step = 1'b1; tick(); btn_left = 2'b00; step = 1'b0;
        chk_all("simul", 4'b0010, 2'b01, 4'h2, 2'b00);
        step = 1'b1; tick();
        chk_all("simul.pop2", 4'b0000, 2'b01, 4'h1, 2'b00);
        tick(); step = 1'b0;
        chk_all("simul.pop3", 4'b0011, 2'b01, 4'h0, 2'b00);

        // Up and right together: up wins.
        btn_up = 2'b01; btn_right = 2'b01; tick(); btn_up = 2'b00; btn_right = 2'b00;
        chk("prio.q", 32'(q_count), 32'h1);
        step = 1'b1; tick(); step = 1'b0;
        chk_all("prio.pop", 4'b0000, 2'b01, 4'h0, 2'b00);

        // Player 1 presses left, player 0 idle.
        btn_left = 2'b10; tick(); btn_left = 2'b00;
        chk("mp.q", 32'(q_count), 32'h4);
        step = 1'b1; tick(); step = 1'b0;
        chk_all("mp.pop", 4'b1100, 2'b10, 4'h0, 2'b00);
        tick();
        chk("mp.turned_clr", 32'(turned), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
